// File: rtl/f1d_pipe.sv
// Elastic DEPTH-stage register pipeline: DEPTH cycles from presentation to Q,
// bubbles collapse under stall, RDY drops only when every stage holds an item.
module f1d_pipe #(
  parameter int              WIDTH   = 16,
  parameter int              DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         CK,
  input  logic                         RN,
  input  logic                         CE,
  input  logic                         FLUSH,
  input  logic [WIDTH-1:0]             D,
  input  logic                         VI,
  output logic                         RDY,
  output logic [WIDTH-1:0]             Q,
  output logic                         VO,
  input  logic                         RDYI,
  output logic [$clog2(DEPTH+1)-1:0]   COUNT
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_d [DEPTH];
  logic [DEPTH-1:0] r_v;
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_v_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_hole;

  // A stage may load when downstream can pop or any stage at/after it is empty.
  always_comb begin
    w_rdy  = '0;
    w_hole = RDYI;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_hole   = w_hole | ~r_v[k];
      w_rdy[k] = w_hole;
    end
  end

  always_comb begin
    w_v_nxt     = r_v;
    w_count_nxt = '0;
    w_v_nxt[0]  = w_rdy[0] ? VI : r_v[0];
    for (int k = 1; k < DEPTH; k++) begin
      w_v_nxt[k] = w_rdy[k] ? r_v[k-1] : r_v[k];
    end
    for (int k = 0; k < DEPTH; k++) begin
      w_count_nxt = w_count_nxt + CW'(w_v_nxt[k]);
    end
  end

  // Flush wins over a frozen pipe; data registers are left untouched by it.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_d[k] <= RST_VAL;
      end
      r_v     <= '0;
      r_count <= '0;
    end else if (FLUSH) begin
      r_v     <= '0;
      r_count <= '0;
    end else if (CE) begin
      if (w_rdy[0]) begin
        r_d[0] <= D;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (w_rdy[k]) begin
          r_d[k] <= r_d[k-1];
        end
      end
      r_v     <= w_v_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign RDY   = w_rdy[0] & ~FLUSH & CE;
  assign VO    = r_v[DEPTH-1] & CE & ~FLUSH;
  assign Q     = r_d[DEPTH-1];
  assign COUNT = r_count;

endmodule

// File: tb/tb_f1d_pipe.sv
// Bench for f1d_pipe: queue-of-items reference model checked every cycle, plus
// directed scenarios with literal expectations and a randomized soak.
module tb_f1d_pipe;

  localparam int DEPTH = 4;

  logic        CK = 1'b0;
  logic        RN = 1'b1;
  logic        CE = 1'b1;
  logic        FLUSH = 1'b0;
  logic [15:0] D = '0;
  logic        VI = 1'b0;
  logic        RDYI = 1'b1;
  logic        RDY;
  logic [15:0] Q;
  logic        VO;
  logic [2:0]  COUNT;

  int errors = 0;
  int checks = 0;

  f1d_pipe #(.WIDTH(16), .DEPTH(DEPTH), .RST_VAL(16'h0000)) dut (
    .CK(CK), .RN(RN), .CE(CE), .FLUSH(FLUSH), .D(D), .VI(VI),
    .RDY(RDY), .Q(Q), .VO(VO), .RDYI(RDYI), .COUNT(COUNT)
  );

  always #5 CK = ~CK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: items in push order, each with the stage index it currently occupies.
  logic [15:0] m_dat [$];
  int          m_pos [$];
  logic [15:0] out_q [$];
  logic [15:0] exp_q [$];

  always @(posedge CK or negedge RN) begin : model_upd
    int   n;
    logic push, pop;
    if (!RN) begin
      m_dat.delete();
      m_pos.delete();
    end else if (FLUSH) begin
      m_dat.delete();
      m_pos.delete();
    end else if (CE) begin
      n    = m_dat.size();
      push = VI && (RDYI || n < DEPTH);
      pop  = (n > 0) && (m_pos[0] == DEPTH - 1) && RDYI;
      // An item advances if downstream pops or there are more free stages ahead of it than items.
      for (int i = 0; i < n; i++) begin
        if (RDYI || ((DEPTH - 1 - m_pos[i]) > i)) m_pos[i] = m_pos[i] + 1;
      end
      if (pop) begin
        void'(m_dat.pop_front());
        void'(m_pos.pop_front());
      end
      if (push) begin
        m_dat.push_back(D);
        m_pos.push_back(0);
      end
    end
  end

  always @(negedge CK) begin : compare
    int   n;
    logic e_vo, e_rdy;
    n     = m_dat.size();
    e_vo  = RN && CE && !FLUSH && (n > 0) && (m_pos[0] == DEPTH - 1);
    e_rdy = CE && !FLUSH && (RDYI || n < DEPTH);
    chk("rdy", {31'd0, RDY}, {31'd0, e_rdy});
    chk("vo", {31'd0, VO}, {31'd0, e_vo});
    chk("count", {29'd0, COUNT}, n);
    if (e_vo) chk("q", {16'd0, Q}, {16'd0, m_dat[0]});
    if (!RN) chk("q_rst", {16'd0, Q}, 32'd0);
    if (RN && VO && RDYI) out_q.push_back(Q);
  end

  logic s_rdy;
  task automatic cyc();
    @(negedge CK);
    s_rdy = RDY;
    @(posedge CK);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    VI = 1'b1;
    D  = d;
    for (int c = 0; c < 50; c++) begin
      cyc();
      if (s_rdy) return;
    end
    chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    VI   = 1'b0;
    RDYI = 1'b1;
    for (int c = 0; c < 40 && COUNT != 0; c++) cyc();
    chk("drain", {29'd0, COUNT}, 32'd0);
    cyc();
  endtask

  task automatic chk_out(input string nm);
    chk({nm, "_len"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      chk(nm, {16'd0, out_q[i]}, {16'd0, exp_q[i]});
    out_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int idx;
    #1 RN = 1'b0;
    #1;
    chk("rst_count", {29'd0, COUNT}, 32'd0);
    chk("rst_vo", {31'd0, VO}, 32'd0);
    chk("rst_q", {16'd0, Q}, 32'd0);
    chk("rst_rdy", {31'd0, RDY}, 32'd1);
    #10 RN = 1'b1;
    cyc();

    // Streaming at full rate.
    out_q.delete();
    for (int i = 1; i <= 8; i++) begin
      D = 16'(i); VI = 1'b1; RDYI = 1'b1;
      cyc();
      chk("stream_rdy", {31'd0, s_rdy}, 32'd1);
      if (i >= 4) begin
        chk("stream_q", {16'd0, Q}, 32'(i - 3));
        chk("stream_vo", {31'd0, VO}, 32'd1);
        chk("stream_cnt", {29'd0, COUNT}, 32'd4);
      end else begin
        chk("fill_cnt", {29'd0, COUNT}, 32'(i));
      end
    end
    drain();
    for (int i = 1; i <= 8; i++) exp_q.push_back(16'(i));
    chk_out("stream_order");

    // Downstream stall, then a single pop with simultaneous push.
    RDYI = 1'b0;
    for (int i = 0; i < 4; i++) send(16'hA000 + 16'(i));
    D = 16'hA004; VI = 1'b1;
    cyc(); cyc();
    chk("stall_rdy", {31'd0, RDY}, 32'd0);
    chk("stall_cnt", {29'd0, COUNT}, 32'd4);
    chk("stall_q", {16'd0, Q}, 32'hA000);
    chk("stall_vo", {31'd0, VO}, 32'd1);
    RDYI = 1'b1;
    cyc();
    RDYI = 1'b0; VI = 1'b0;
    chk("pop1_cnt", {29'd0, COUNT}, 32'd4);
    chk("pop1_q", {16'd0, Q}, 32'hA001);
    drain();
    for (int i = 0; i < 5; i++) exp_q.push_back(16'hA000 + 16'(i));
    chk_out("stall_order");

    // Bubbles collapse while stalled.
    RDYI = 1'b0;
    for (int i = 0; i < 8; i++) begin
      D = 16'hC000 + 16'(i); VI = (i % 2 == 0);
      cyc();
    end
    VI = 1'b0;
    chk("bub_cnt", {29'd0, COUNT}, 32'd4);
    chk("bub_q", {16'd0, Q}, 32'hC000);
    chk("bub_rdy", {31'd0, RDY}, 32'd0);
    drain();
    exp_q = '{16'hC000, 16'hC002, 16'hC004, 16'hC006};
    chk_out("bub_order");

    // Flush discards contents and blocks the presented item.
    RDYI = 1'b0;
    for (int i = 1; i <= 3; i++) send(16'hD000 + 16'(i));
    VI = 1'b0;
    cyc();
    chk("pre_flush_cnt", {29'd0, COUNT}, 32'd3);
    FLUSH = 1'b1; VI = 1'b1; D = 16'hBEEF;
    #1;
    chk("flush_rdy", {31'd0, RDY}, 32'd0);
    cyc();
    FLUSH = 1'b0; VI = 1'b0;
    chk("flush_cnt", {29'd0, COUNT}, 32'd0);
    chk("flush_vo", {31'd0, VO}, 32'd0);
    RDYI = 1'b1; D = 16'h1234; VI = 1'b1;
    cyc();
    VI = 1'b0;
    cyc(); cyc(); cyc();
    chk("flush_q", {16'd0, Q}, 32'h1234);
    chk("flush_vo2", {31'd0, VO}, 32'd1);
    drain();
    exp_q = '{16'h1234};
    chk_out("flush_order");

    // Clock-enable freeze mid-stream.
    idx = 0; RDYI = 1'b1;
    for (int c = 0; c < 20; c++) begin
      CE = !(c >= 8 && c < 13);
      VI = 1'b1; D = 16'h2000 + 16'(idx);
      cyc();
      if (s_rdy) idx++;
      if (!CE) begin
        chk("ce_cnt", {29'd0, COUNT}, 32'd4);
        chk("ce_rdy", {31'd0, RDY}, 32'd0);
        chk("ce_vo", {31'd0, VO}, 32'd0);
      end
    end
    CE = 1'b1;
    drain();
    for (int i = 0; i < idx; i++) exp_q.push_back(16'h2000 + 16'(i));
    chk_out("ce_order");

    // Asynchronous reset between edges with a full pipe.
    RDYI = 1'b0;
    for (int i = 0; i < 4; i++) send(16'h3000 + 16'(i));
    VI = 1'b0;
    chk("full_cnt", {29'd0, COUNT}, 32'd4);
    #3 RN = 1'b0;
    #1;
    chk("arst_q", {16'd0, Q}, 32'd0);
    chk("arst_vo", {31'd0, VO}, 32'd0);
    chk("arst_cnt", {29'd0, COUNT}, 32'd0);
    @(negedge CK);
    #2 RN = 1'b1;
    @(posedge CK); #1;
    out_q.delete();
    RDYI = 1'b1;
    for (int i = 0; i < 6; i++) send(16'h3100 + 16'(i));
    drain();
    for (int i = 0; i < 6; i++) exp_q.push_back(16'h3100 + 16'(i));
    chk_out("post_rst_order");

    // Randomized soak against the model.
    for (int c = 0; c < 3000; c++) begin
      VI    = ($urandom_range(0, 3) != 0);
      RDYI  = (c % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      CE    = ($urandom_range(0, 15) != 0);
      FLUSH = ($urandom_range(0, 60) == 0);
      D     = 16'($urandom);
      cyc();
    end
    CE = 1'b1; FLUSH = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
